// File: rtl/fir_axil_slave_if.sv
// AXI4-Lite bus bundle for the FIR register slave.
interface fir_axil_slave_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/fir_axil_slave.sv
// AXI4-Lite register file around a 4-tap sequential MAC FIR engine.
// A DIN write while enabled and idle pushes a sample and runs one MAC step
// per cycle; the result lands in DOUT with STATUS.VALID set.
module fir_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int COEF_WIDTH         = 16
) (
    input  logic            ACLK,
    input  logic            ARESET,
    fir_axil_slave_if.slave s_axi
);
    localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 2;
    localparam int DW     = C_S_AXI_DATA_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DIN    = 3'd1;
    localparam logic [2:0] A_DOUT   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      k_q, k_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [3:0][SAMPLE_WIDTH-1:0]    x_q, x_d;
    logic [3:0][DW-1:0]              coef_q, coef_d;
    logic                            en_q, en_d;
    logic [DW-1:0]                   din_q, din_d;
    logic [DW-1:0]                   dout_q, dout_d;
    logic                            valid_q, valid_d;
    logic                            bvalid_q, bvalid_d;
    logic [1:0]                      bresp_q, bresp_d;
    logic                            rvalid_q, rvalid_d;
    logic [DW-1:0]                   rdata_q, rdata_d;

    logic                            wr_en, rd_en, busy, push, clr;
    logic [2:0]                      wr_idx, rd_idx;
    logic [DW-1:0]                   ctrl_w;
    logic signed [PROD_W-1:0]        prod;
    logic                            unused_ok;

    // Byte-strobe merge of new write data over an existing register value.
    function automatic logic [DW-1:0] wmerge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [DW/8-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < DW/8; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Both write channels are taken together; reset masks the readies.
    assign wr_en  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~ARESET;
    assign rd_en  = s_axi.S_AXI_ARVALID & ~rvalid_q & ~ARESET;
    assign wr_idx = s_axi.S_AXI_AWADDR[4:2];
    assign rd_idx = s_axi.S_AXI_ARADDR[4:2];
    assign busy   = (state_q != S_IDLE);
    assign prod   = PROD_W'($signed(coef_q[k_q][COEF_WIDTH-1:0]))
                  * PROD_W'($signed(x_q[k_q]));

    assign s_axi.S_AXI_AWREADY = wr_en;
    assign s_axi.S_AXI_WREADY  = wr_en;
    assign s_axi.S_AXI_ARREADY = rd_en;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         acc_q[ACC_W-1:DW]};

    // Bus decode, register updates and FIR sequencing.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        x_d      = x_q;
        coef_d   = coef_q;
        en_d     = en_q;
        din_d    = din_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        push     = 1'b0;
        clr      = 1'b0;
        ctrl_w   = '0;

        if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_idx)
                A_CTRL: begin
                    // CLR has no storage: it reads back as 0, so merge over 0.
                    ctrl_w = wmerge({{(DW-1){1'b0}}, en_q}, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                    en_d   = ctrl_w[0];
                    clr    = ctrl_w[1];
                end
                A_DIN: begin
                    if (busy) bresp_d = RESP_SLVERR;
                    else begin
                        din_d = wmerge(din_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
                        push  = en_q;
                    end
                end
                A_DOUT, A_STATUS: bresp_d = RESP_SLVERR;
                default: coef_d[wr_idx[1:0]] = wmerge(coef_q[wr_idx[1:0]], s_axi.S_AXI_WDATA,
                                                      s_axi.S_AXI_WSTRB);
            endcase
        end

        if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            case (rd_idx)
                A_CTRL:   rdata_d = {{(DW-1){1'b0}}, en_q};
                A_DIN:    rdata_d = din_q;
                A_DOUT:   rdata_d = dout_q;
                A_STATUS: rdata_d = {{(DW-2){1'b0}}, busy, valid_q};
                default:  rdata_d = coef_q[rd_idx[1:0]];
            endcase
            // Cleared before the FSM below so a coincident DONE set wins.
            if (rd_idx == A_DOUT) valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: if (push) begin
                x_d     = {x_q[2:0], s_axi.S_AXI_WDATA[SAMPLE_WIDTH-1:0]};
                acc_d   = '0;
                k_d     = 2'd0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_DONE;
            end
            S_DONE: begin
                dout_d  = acc_q[DW-1:0];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // CLR flushes the taps and abandons any result in progress.
        if (clr) begin
            x_d     = '0;
            state_d = S_IDLE;
        end
    end

    // State registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            coef_q   <= '0;
            en_q     <= 1'b0;
            din_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            en_q     <= en_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: doc/fir_axil_slave.md
Name: fir_axil_slave

Overview:
AXI4-Lite responder that wraps a 4-tap sequential multiply-accumulate FIR engine behind a memory-mapped register file. It sits on the PS/interconnect side of the FIR IP and is driven by the team's AXI VIP master in block-design benches. A write to the sample register pushes one sample into the delay line and starts a 4-cycle MAC. Software polls STATUS and reads the result from DOUT.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; covers 8 word registers.
SAMPLE_WIDTH, 16, signed sample width taken from DIN[SAMPLE_WIDTH-1:0].
COEF_WIDTH, 16, signed coefficient width taken from COEFn[COEF_WIDTH-1:0].

Ports:
ACLK  in  1  clock; all logic is synchronous to the rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.

Behaviour:
Reset: while ARESET=1, all READY and VALID outputs are 0, RDATA/BRESP/RRESP are 0, and all registers, the delay line, the accumulator and the FSM are cleared (FSM to IDLE).

Register map (word index = addr[4:2]; addr[1:0] ignored):
- 0x00 CTRL: bit0 EN; bit1 CLR, write-1 self-clearing, reads 0.
- 0x04 DIN: R/W; readback returns the last written value.
- 0x08 DOUT: read-only.
- 0x0C STATUS: read-only; bit0 VALID, bit1 BUSY.
- 0x10 to 0x1C: COEF0..COEF3, R/W.
- WSTRB is honoured per byte on CTRL, DIN and COEFn.
- Writes to DOUT or STATUS are ignored and answered with SLVERR.

Write channel:
- AWREADY and WREADY pulse together for one cycle when AWVALID=1, WVALID=1 and BVALID=0. Neither channel is accepted alone.
- BVALID rises the cycle after acceptance and holds until BREADY. BRESP is OKAY unless stated otherwise.

Read channel:
- ARREADY pulses for one cycle when ARVALID=1 and RVALID=0.
- RVALID rises the next cycle with RDATA registered; RDATA and RVALID hold until RREADY.
- RRESP is always OKAY.

Sample push:
- A DIN write accepted while EN=1 and FSM=IDLE shifts the delay line on the accept edge: x3<=x2, x2<=x1, x1<=x0, x0<=WDATA[15:0]. This is the only event that leaves IDLE.
- DIN write while EN=0: the register stores the value, no push, OKAY.
- DIN write while FSM≠IDLE: no store, no push, BRESP=SLVERR.

FSM:
- IDLE -> MAC at the push edge; BUSY=1 from the following cycle; accumulator is cleared.
- MAC: steps k=0..3 on 4 consecutive edges, acc += sext(COEFk)*sext(xk). Products are 32-bit signed; acc is 34-bit.
- MAC -> DONE after k=3.
- DONE -> IDLE: DOUT <= acc[31:0] (two's-complement wrap), VALID<=1, BUSY<=0.
- Timing: DOUT and VALID are visible exactly 5 cycles after the push edge.

VALID clear rules:
- VALID clears when a DOUT read is accepted (ARREADY cycle).
- If that read coincides with the DONE update, set wins and VALID remains 1; the read returns the old DOUT.

CLR:
- Zeroes the delay line and aborts any MAC (FSM->IDLE, BUSY=0) on the accept edge.
- DOUT, VALID, COEFn and EN are unchanged.

Other rules:
- COEF writes during MAC take effect for any step k not yet executed.
- ARESET asserted mid-transaction drops all VALID outputs immediately. No response is owed for in-flight transactions.

Test Plan:
- Reset, then read all 8 addresses -> all RDATA=0x00000000, RRESP=OKAY.
- Write COEF0..3=1,2,3,4, CTRL=1, DIN=1 -> STATUS=0x1 and DOUT=0x00000001 from 5 cycles after the push; after pushing 2,3,4 -> DOUT=20 (0x14).
- Write COEF0=0xFFFF, COEF1..3=0, DIN=0x7FFF -> DOUT=0xFFFF8001; a subsequent DOUT read clears VALID, so STATUS reads 0x0.
- Write DIN twice back-to-back with BREADY held high -> second BRESP=SLVERR, DOUT reflects the first sample only; DIN write with EN=0 -> OKAY, STATUS stays 0x0.
- Push 5 with all COEF=1, then write CTRL=0x3 mid-MAC -> BUSY=0 next cycle, DOUT unchanged, VALID not set; next push of 7 -> DOUT=7.
- Hold AWVALID without WVALID for 10 cycles -> AWREADY stays 0; then assert WVALID -> single accept, BVALID the next cycle, held until BREADY.
